// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry and the parity helper
// used by both the transmit framer and the receive side.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GAP
  } uart_state_t;

  function automatic logic uart_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-entry holding register feeding an 11-cycle
// START/DATA/PARITY/GAP frame, one serial bit per clock.
module uart_tx_framer
  import uart_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              TxD_start,
  input  logic [DATA_W-1:0] TxD_data,
  input  logic              TxD_force_err,
  output logic              TxD_ready,
  output logic              TxD_busy,
  output logic              TxD_frame_start,
  output logic              TxD,
  output logic              TxD_done
);

  uart_state_t       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_ferr;
  logic              r_hold_valid;
  logic              r_par;
  logic [2:0]        r_idx;
  logic              r_ready;
  logic              r_busy;
  logic              r_frame_start;
  logic              r_txd;
  logic              r_done;

  logic w_accept;
  logic w_load;

  // Accept needs an empty holder and load needs a full one, so they never
  // coincide on the same edge.
  assign w_accept = TxD_start && !r_hold_valid;
  assign w_load   = r_hold_valid &&
                    ((r_state == S_IDLE) || (r_state == S_GAP));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_hold_data   <= '0;
      r_hold_ferr   <= 1'b0;
      r_hold_valid  <= 1'b0;
      r_par         <= 1'b0;
      r_idx         <= 3'd0;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_start <= 1'b0;
      r_txd         <= 1'b1;
      r_done        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_data  <= TxD_data;
        r_hold_ferr  <= TxD_force_err;
        r_hold_valid <= 1'b1;
        r_ready      <= 1'b0;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
        r_ready      <= 1'b1;
      end

      r_frame_start <= 1'b0;
      r_done        <= 1'b0;

      unique case (r_state)
        S_IDLE, S_GAP: begin
          r_txd <= 1'b1;
          if (w_load) begin
            r_shift       <= r_hold_data;
            r_par         <= uart_parity(r_hold_data) ^ r_hold_ferr;
            r_state       <= S_START;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_START: begin
          r_state <= S_DATA;
          r_idx   <= 3'd0;
          r_txd   <= r_shift[0];
          r_shift <= {1'b0, r_shift[DATA_W-1:1]};
        end
        S_DATA: begin
          if (r_idx == 3'd7) begin
            r_state <= S_PARITY;
            r_txd   <= r_par;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
          end
        end
        S_PARITY: begin
          r_state <= S_GAP;
          r_txd   <= 1'b1;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TxD_ready       = r_ready;
  assign TxD_busy        = r_busy;
  assign TxD_frame_start = r_frame_start;
  assign TxD             = r_txd;
  assign TxD_done        = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a small loopback receiver model.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_framer;
  import uart_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       TxD_start = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic       TxD_force_err = 1'b0;
  logic       TxD_ready;
  logic       TxD_busy;
  logic       TxD_frame_start;
  logic       TxD;
  logic       TxD_done;

  int total = 0;
  int bad = 0;

  uart_tx_framer dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .TxD_start      (TxD_start),
    .TxD_data       (TxD_data),
    .TxD_force_err  (TxD_force_err),
    .TxD_ready      (TxD_ready),
    .TxD_busy       (TxD_busy),
    .TxD_frame_start(TxD_frame_start),
    .TxD            (TxD),
    .TxD_done       (TxD_done)
  );

  always #5 Clk = ~Clk;

  // Loopback receiver: frame_start marks START, then 8 data bits, parity, gap.
  logic [7:0] rx_sh;
  logic [7:0] RxD_data;
  logic       Error;
  logic       RxD_idle;
  logic       rx_act;
  int         rx_cnt;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      rx_act   <= 1'b0;
      rx_cnt   <= 0;
      RxD_idle <= 1'b1;
      Error    <= 1'b0;
      rx_sh    <= 8'h00;
      RxD_data <= 8'h00;
    end else if (TxD_frame_start) begin
      rx_act   <= 1'b1;
      rx_cnt   <= 0;
      RxD_idle <= 1'b0;
    end else if (rx_act) begin
      if (rx_cnt < 8) begin
        rx_sh[rx_cnt] <= TxD;
        rx_cnt        <= rx_cnt + 1;
      end else if (rx_cnt == 8) begin
        RxD_data <= rx_sh;
        Error    <= (^rx_sh) ^ TxD;
        rx_cnt   <= 9;
      end else begin
        rx_act   <= 1'b0;
        RxD_idle <= 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic e);
    TxD_data      = d;
    TxD_force_err = e;
    TxD_start     = 1'b1;
    @(negedge Clk);
    TxD_start     = 1'b0;
    TxD_data      = ~d;
    TxD_force_err = ~e;
  endtask

  task automatic collect_frame(output logic [7:0] bits, output logic par,
                               output logic gap_ok, output logic ok,
                               output int lat);
    ok = 1'b0; bits = 8'h00; par = 1'b0; gap_ok = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clk);
      lat = i + 1;
      if (TxD_frame_start) ok = 1'b1;
    end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge Clk);
        bits[i] = TxD;
      end
      @(negedge Clk);
      par = TxD;
      @(negedge Clk);
      gap_ok = TxD_done && TxD && TxD_busy;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    TxD_start = 1'b1;
    TxD_data = 8'h77;
    repeat (3) @(negedge Clk);
    TxD_start = 1'b0;
    total++;
    if ({TxD, TxD_busy, TxD_ready, TxD_frame_start, TxD_done} !== 5'b10100) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=10100",
               {TxD, TxD_busy, TxD_ready, TxD_frame_start, TxD_done});
    end
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    total++;
    if ({TxD_busy, TxD_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_start_ignored got=%b exp=01", {TxD_busy, TxD_ready});
    end
  endtask

  task automatic test_single;
    logic [7:0] b; logic p, g, ok; int lat;
    send(8'hA5, 1'b0);
    total++;
    if (TxD_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready_low got=%b exp=0", TxD_ready);
    end
    collect_frame(b, p, g, ok, lat);
    total++;
    if (!ok || lat != 1) begin
      bad++; $display("FAIL single_latency got=%0d exp=1 ok=%b", lat, ok);
    end
    total++;
    if (b !== 8'hA5) begin
      bad++; $display("FAIL single_bits got=%h exp=a5", b);
    end
    total++;
    if (p !== 1'b0) begin
      bad++; $display("FAIL single_parity got=%b exp=0", p);
    end
    total++;
    if (g !== 1'b1) begin
      bad++; $display("FAIL single_done got=%b exp=1", g);
    end
    total++;
    if ({TxD_busy, TxD_done, TxD} !== 3'b001) begin
      bad++; $display("FAIL single_idle got=%b exp=001", {TxD_busy, TxD_done, TxD});
    end
    total++;
    if ({RxD_data, Error} !== {8'hA5, 1'b0}) begin
      bad++; $display("FAIL single_rx got=%h/%b exp=a5/0", RxD_data, Error);
    end
  endtask

  task automatic test_back_to_back;
    logic l_fs[0:23]; logic l_rdy[0:23]; logic l_tx[0:23]; logic l_dn[0:23];
    logic l_bz[0:23];
    logic [22:0] exp_tx;
    exp_tx = 23'b11011111111111000000011;
    send(8'h01, 1'b0);
    @(negedge Clk);
    l_fs[0] = TxD_frame_start; l_rdy[0] = TxD_ready; l_tx[0] = TxD;
    l_dn[0] = TxD_done; l_bz[0] = TxD_busy;
    TxD_data = 8'hFF; TxD_force_err = 1'b0; TxD_start = 1'b1;
    for (int c = 1; c < 24; c++) begin
      @(negedge Clk);
      TxD_start = 1'b0; TxD_data = 8'h5A;
      l_fs[c] = TxD_frame_start; l_rdy[c] = TxD_ready; l_tx[c] = TxD;
      l_dn[c] = TxD_done; l_bz[c] = TxD_busy;
    end
    for (int c = 0; c < 23; c++) begin
      total++;
      if (l_fs[c] !== (c == 0 || c == int'(FRAME_LEN))) begin
        bad++; $display("FAIL b2b_fs c=%0d got=%b", c, l_fs[c]);
      end
      total++;
      if (l_tx[c] !== exp_tx[c]) begin
        bad++; $display("FAIL b2b_txd c=%0d got=%b exp=%b", c, l_tx[c], exp_tx[c]);
      end
      total++;
      if (l_dn[c] !== (c == 10 || c == 21)) begin
        bad++; $display("FAIL b2b_done c=%0d got=%b", c, l_dn[c]);
      end
    end
    for (int c = 1; c < 12; c++) begin
      total++;
      if (l_rdy[c] !== (c == 11)) begin
        bad++; $display("FAIL b2b_ready c=%0d got=%b", c, l_rdy[c]);
      end
    end
    total++;
    if ({l_bz[11], l_bz[21], l_bz[22]} !== 3'b110) begin
      bad++; $display("FAIL b2b_busy got=%b exp=110", {l_bz[11], l_bz[21], l_bz[22]});
    end
  endtask

  task automatic test_error;
    logic [7:0] b; logic p, g, ok; int lat;
    send(8'h3C, 1'b1);
    collect_frame(b, p, g, ok, lat);
    total++;
    if (!ok || b !== 8'h3C || p !== 1'b1) begin
      bad++; $display("FAIL err_frame got=%h/%b ok=%b exp=3c/1", b, p, ok);
    end
    total++;
    if ({RxD_data, Error} !== {8'h3C, 1'b1}) begin
      bad++; $display("FAIL err_rx got=%h/%b exp=3c/1", RxD_data, Error);
    end
  endtask

  task automatic test_full;
    logic l_fs[0:24]; logic [7:0] b2; logic [7:0] rx21; logic bz22;
    b2 = 8'h00;
    send(8'h22, 1'b0);
    @(negedge Clk);
    l_fs[0] = TxD_frame_start;
    TxD_data = 8'h11; TxD_force_err = 1'b0; TxD_start = 1'b1;
    for (int c = 1; c < 25; c++) begin
      @(negedge Clk);
      TxD_data = 8'h55;
      TxD_start = (c < 6);
      l_fs[c] = TxD_frame_start;
      if (c >= 12 && c <= 19) b2[c-12] = TxD;
      if (c == 21) rx21 = RxD_data;
      if (c == 22) bz22 = TxD_busy;
    end
    TxD_start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      total++;
      if (l_fs[c] !== (c == 0 || c == 11)) begin
        bad++; $display("FAIL full_fs c=%0d got=%b", c, l_fs[c]);
      end
    end
    total++;
    if (b2 !== 8'h11) begin
      bad++; $display("FAIL full_held_bits got=%h exp=11", b2);
    end
    total++;
    if (rx21 !== 8'h11) begin
      bad++; $display("FAIL full_rx got=%h exp=11", rx21);
    end
    total++;
    if (bz22 !== 1'b0) begin
      bad++; $display("FAIL full_idle_busy got=%b exp=0", bz22);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    send(8'hF0, 1'b0);
    @(negedge Clk);
    TxD_data = 8'h0F; TxD_start = 1'b1;
    @(negedge Clk);
    TxD_start = 1'b0;
    repeat (4) @(negedge Clk);
    total++;
    if ({TxD_busy, TxD} !== 2'b11) begin
      bad++; $display("FAIL mid_bit4 got=%b exp=11", {TxD_busy, TxD});
    end
    Rst_n = 1'b0;
    @(negedge Clk);
    total++;
    if ({TxD, TxD_busy, TxD_ready, TxD_frame_start, TxD_done} !== 5'b10100) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=10100",
               {TxD, TxD_busy, TxD_ready, TxD_frame_start, TxD_done});
    end
    Rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (TxD_done || TxD_frame_start || TxD_busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mid_discard got=%0d exp=0", seen);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] lb[3]; logic lp[3];
    logic [7:0] b; logic p, g, ok; int lat;
    lb = '{8'h00, 8'h80, 8'hFF};
    lp = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      send(lb[k], 1'b0);
      collect_frame(b, p, g, ok, lat);
      total++;
      if (!ok || p !== lp[k] || g !== 1'b1) begin
        bad++; $display("FAIL loop_par k=%0d got=%b ok=%b exp=%b", k, p, ok, lp[k]);
      end
      total++;
      if ({RxD_data, Error, RxD_idle} !== {lb[k], 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL loop_rx k=%0d got=%h/%b/%b exp=%h/0/1",
                 k, RxD_data, Error, RxD_idle, lb[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_full();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
